// File: rtl/demux_4ch_deserializer_if.sv
// Bus bundle between a demux_1_4 bit source / word consumer and demux_4ch_deserializer.
// The master is the environment; the slave is the deserializer.
interface demux_4ch_deserializer_if #(
    parameter int WIDTH = 8
);
    logic               bit_valid;
    logic [1:0]         sel;
    logic               y0;
    logic               y1;
    logic               y2;
    logic               y3;
    logic               flush;
    logic               clear_ovf;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [3:0]         overflow;

    modport master (
        output bit_valid, sel, y0, y1, y2, y3, flush, clear_ovf, out_ready,
        input  out_data, out_valid, overflow
    );

    modport slave (
        input  bit_valid, sel, y0, y1, y2, y3, flush, clear_ovf, out_ready,
        output out_data, out_valid, overflow
    );
endinterface

// File: rtl/demux_4ch_deserializer.sv
// Four independent serial-to-parallel channels fed by a 1:4 demux, each with a
// single-entry holding register, valid/ready output and sticky overflow flag.
module demux_4ch_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    demux_4ch_deserializer_if.slave dif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {EMPTY, FULL} hold_state_e;

    logic [WIDTH-1:0] sh_q     [4];
    logic [WIDTH-1:0] sh_d     [4];
    logic [CW-1:0]    cnt_q    [4];
    logic [CW-1:0]    cnt_d    [4];
    logic [WIDTH-1:0] hold_q   [4];
    logic [WIDTH-1:0] hold_d   [4];
    hold_state_e      state_q  [4];
    hold_state_e      state_d  [4];
    logic [3:0]       ovf_q;
    logic [3:0]       ovf_d;
    logic [WIDTH-1:0] shifted  [4];
    logic [3:0]       complete;
    logic [3:0]       y_bus;
    logic             b;

    assign y_bus = {dif.y3, dif.y2, dif.y1, dif.y0};
    assign b     = y_bus[dif.sel];

    always_comb begin
        // NOTE: every comb output gets a default before any branch, so no latch can be inferred.
        ovf_d    = dif.clear_ovf ? 4'b0000 : ovf_q;
        complete = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            sh_d[c]    = sh_q[c];
            cnt_d[c]   = cnt_q[c];
            hold_d[c]  = hold_q[c];
            state_d[c] = state_q[c];
            shifted[c] = MSB_FIRST ? {sh_q[c][WIDTH-2:0], b} : {b, sh_q[c][WIDTH-1:1]};

            // flush wins over a coincident strobe, discarding that bit
            if (dif.flush) begin
                sh_d[c]  = '0;
                cnt_d[c] = '0;
            end else if (dif.bit_valid && (dif.sel == 2'(c))) begin
                if (cnt_q[c] == LAST) begin
                    complete[c] = 1'b1;
                    sh_d[c]     = '0;
                    cnt_d[c]    = '0;
                end else begin
                    sh_d[c]  = shifted[c];
                    cnt_d[c] = cnt_q[c] + CW'(1);
                end
            end

            case (state_q[c])
                EMPTY: begin
                    if (complete[c]) begin
                        state_d[c] = FULL;
                        hold_d[c]  = shifted[c];
                    end
                end
                FULL: begin
                    if (complete[c]) begin
                        // consumer taking the old word this cycle frees the slot without a bubble
                        if (dif.out_ready[c]) hold_d[c] = shifted[c];
                        else                  ovf_d[c]  = 1'b1;
                    end else if (dif.out_ready[c]) begin
                        state_d[c] = EMPTY;
                    end
                end
                default: state_d[c] = EMPTY;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the holding registers are reset too, because out_data must read 0 after reset.
            for (int c = 0; c < 4; c++) begin
                sh_q[c]    <= '0;
                cnt_q[c]   <= '0;
                hold_q[c]  <= '0;
                state_q[c] <= EMPTY;
            end
            ovf_q <= 4'b0000;
        end else begin
            for (int c = 0; c < 4; c++) begin
                sh_q[c]    <= sh_d[c];
                cnt_q[c]   <= cnt_d[c];
                hold_q[c]  <= hold_d[c];
                state_q[c] <= state_d[c];
            end
            ovf_q <= ovf_d;
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_out
        assign dif.out_data[c*WIDTH +: WIDTH] = hold_q[c];
        assign dif.out_valid[c]               = (state_q[c] == FULL);
    end
    assign dif.overflow = ovf_q;

endmodule
